// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Shared definitions for the I2S transmit and microphone receive paths:
//   the link controller state encoding and default link geometry.
//   Defaults give 3.072 MHz SCK and 48 kHz frames from a 98.304 MHz clock.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_t;

  localparam int DEF_SAMPLE_WIDTH = 16;  // bits per channel sample
  localparam int DEF_SLOT_WIDTH   = 32;  // SCK periods per channel slot
  localparam int DEF_SCK_DIV      = 32;  // clk_in cycles per SCK period

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen
//   Bit-clock generator for an I2S bus controller. A divider counts
//   0..SCK_DIV-1 while run_in is high; SCK is low for the first half of the
//   count and high for the second half.
//
// Ports
//   clk_in        system clock
//   rst_in        asynchronous active-high reset
//   run_in        count this cycle; when low the divider is held at 0
//   halt_in       return the divider to 0 at the end of this cycle
//   sck_out       registered bit clock
//   fall_evt_out  strobe: cycle with divider count 0 (SCK low phase starts)
//   rise_evt_out  strobe: cycle with divider count SCK_DIV/2 (SCK high phase starts)
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SCK_DIV = DEF_SCK_DIV
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic run_in,
  input  logic halt_in,
  output logic sck_out,
  output logic fall_evt_out,
  output logic rise_evt_out
);

  localparam int DCW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(SCK_DIV - 1);
  localparam logic [DCW-1:0] DIV_HALF = DCW'(SCK_DIV / 2);

  logic [DCW-1:0] div_cnt;
  logic [DCW-1:0] div_nxt;

  assign fall_evt_out = run_in && (div_cnt == '0);
  assign rise_evt_out = run_in && (div_cnt == DIV_HALF);

  always_comb begin
    div_nxt = div_cnt + 1'b1;
    if (!run_in || halt_in || (div_cnt == DIV_LAST))
      div_nxt = '0;
  end

  // SCK is registered from the next count so its level always matches the
  // count held during the same cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= '0;
      sck_out <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      sck_out <= run_in && !halt_in && (div_nxt >= DIV_HALF);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter
//   Philips I2S bus controller for a stereo DAC/codec. Accepts one stereo
//   sample pair through a valid/ready handshake into a single holding entry,
//   generates SCK/WS itself and shifts each frame out MSB first with the
//   standard one-bit delay after each WS transition.
//
// Ports
//   clk_in            system/audio clock
//   rst_in            asynchronous active-high reset
//   enable_in         run request (level); dropping it finishes the frame first
//   left_in/right_in  signed samples, captured when valid && ready
//   sample_valid_in   sample pair valid
//   sample_ready_out  holding entry empty
//   i2s_sck_out       bit clock
//   i2s_ws_out        word select (0 = left, 1 = right)
//   i2s_sd_out        serial data
//   underrun_out      one-cycle pulse when a frame starts with no sample held
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int SCK_DIV      = DEF_SCK_DIV
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    i2s_sck_out,
  output logic                    i2s_ws_out,
  output logic                    i2s_sd_out,
  output logic                    underrun_out
);

  localparam int FRAME_W = 2 * SLOT_WIDTH;
  localparam int BCW     = $clog2(FRAME_W);
  localparam logic [BCW-1:0] LAST_BIT    = BCW'(FRAME_W - 1);
  localparam logic [BCW-1:0] WS_HI_FIRST = BCW'(SLOT_WIDTH - 1);
  localparam logic [BCW-1:0] WS_HI_LAST  = BCW'(FRAME_W - 2);

  i2s_state_t state;
  logic [BCW-1:0] bit_cnt;
  logic buf_full;
  logic signed [SAMPLE_WIDTH-1:0] buf_left;
  logic signed [SAMPLE_WIDTH-1:0] buf_right;
  logic [FRAME_W-1:0] frame_sr;

  logic active;
  logic fall_evt;
  logic at_last;
  logic stop_evt;
  logic load_evt;
  logic xfer;
  logic rise_evt_unused;  // rise strobe is consumed by the receiver only

  // Each slot carries its sample MSB first, zero-padded to the slot width.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic signed [SAMPLE_WIDTH-1:0] l,
    input logic signed [SAMPLE_WIDTH-1:0] r
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1 -: SAMPLE_WIDTH]    = l;
    f[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = r;
    return f;
  endfunction

  // The IDLE cycle that sees enable_in already counts as divider count 0, so
  // the start-up frame load happens on that very cycle.
  assign active   = (state != ST_IDLE) || enable_in;
  assign at_last  = (state != ST_IDLE) && (bit_cnt == LAST_BIT);
  assign stop_evt = fall_evt && at_last && (state == ST_DRAIN) && !enable_in;
  assign load_evt = fall_evt && ((state == ST_IDLE) || (at_last && !stop_evt));
  assign xfer     = sample_valid_in && !buf_full;

  assign sample_ready_out = !buf_full;

  i2s_clk_gen #(
    .SCK_DIV(SCK_DIV)
  ) u_clk_gen (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .run_in      (active),
    .halt_in     (stop_evt),
    .sck_out     (i2s_sck_out),
    .fall_evt_out(fall_evt),
    .rise_evt_out(rise_evt_unused)
  );

  // Control: state, bit position, buffer flag and the registered pins.
  // SD and WS are one fall event behind bit_cnt, which yields the one-bit
  // I2S delay: WS flips one SCK before each slot's MSB reaches SD.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      buf_full     <= 1'b0;
      i2s_ws_out   <= 1'b0;
      i2s_sd_out   <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      underrun_out <= load_evt && !buf_full;
      // A transfer landing on an empty-buffer load is kept for the next frame.
      buf_full <= load_evt ? xfer : (buf_full || xfer);

      case (state)
        ST_IDLE:  if (enable_in) state <= ST_RUN;
        ST_RUN:   if (!enable_in) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable_in)     state <= ST_RUN;
          else if (stop_evt) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase

      if (stop_evt) begin
        bit_cnt    <= '0;
        i2s_ws_out <= 1'b0;
        i2s_sd_out <= 1'b0;
      end else if (fall_evt) begin
        bit_cnt    <= ((state == ST_IDLE) || at_last) ? '0 : bit_cnt + 1'b1;
        i2s_ws_out <= (state != ST_IDLE) && (bit_cnt >= WS_HI_FIRST) &&
                      (bit_cnt <= WS_HI_LAST);
        i2s_sd_out <= (state != ST_IDLE) && frame_sr[FRAME_W-1];
      end
    end
  end

  // Data: holding entry and frame shift register.
  always_ff @(posedge clk_in) begin
    if (xfer) begin
      buf_left  <= left_in;
      buf_right <= right_in;
    end
    if (load_evt)
      frame_sr <= buf_full ? pack_frame(buf_left, buf_right) : '0;
    else if (fall_evt)
      frame_sr <= frame_sr << 1;
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter
//   Directed bench for i2s_transmitter with SCK_DIV=4, SLOT_WIDTH=32,
//   SAMPLE_WIDTH=16 (256-cycle frames). SD/WS are captured at every SCK
//   rising edge; capture index 0 after enable is the idle bit ahead of the
//   frame, indices 1..64 carry frame bits 0..63.
module tb_i2s_transmitter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        enable_in = 1'b0;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        sample_valid_in = 1'b0;
  logic        sample_ready_out;
  logic        i2s_sck_out;
  logic        i2s_ws_out;
  logic        i2s_sd_out;
  logic        underrun_out;

  logic clk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic sd_q[$];
  logic ws_q[$];
  logic sck_prev = 1'b0;
  logic ready_prev = 1'b1;
  int   und_cnt = 0;
  int   und_first = -1;
  int   und_last = -1;
  int   ready_rises = 0;
  int   cyc = 0;
  logic stream_on = 1'b0;
  int   acc = 0;

  i2s_transmitter #(
    .SAMPLE_WIDTH(16),
    .SLOT_WIDTH  (32),
    .SCK_DIV     (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .left_in         (left_in),
    .right_in        (right_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .i2s_sck_out     (i2s_sck_out),
    .i2s_ws_out      (i2s_ws_out),
    .i2s_sd_out      (i2s_sd_out),
    .underrun_out    (underrun_out)
  );

  initial begin
    wait (clk_en);
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic pre;
    pre = sample_valid_in && sample_ready_out;
    @(posedge clk_in);
    #1;
    cyc++;
    if (i2s_sck_out && !sck_prev) begin
      sd_q.push_back(i2s_sd_out);
      ws_q.push_back(i2s_ws_out);
    end
    sck_prev = i2s_sck_out;
    if (underrun_out) begin
      und_cnt++;
      if (und_first < 0) und_first = cyc;
      und_last = cyc;
    end
    if (sample_ready_out && !ready_prev) ready_rises++;
    ready_prev = sample_ready_out;
    if (stream_on && pre) begin
      acc++;
      left_in  = 16'(32'h1000 + acc);
      right_in = 16'(32'h2000 + acc);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    sd_q.delete();
    ws_q.delete();
    und_cnt = 0;
    und_first = -1;
    und_last = -1;
    ready_rises = 0;
  endtask

  function automatic logic [15:0] word_at(input int start);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      w = {w[14:0], (start + i < sd_q.size()) ? sd_q[start + i] : 1'bx};
    return w;
  endfunction

  function automatic int ones_in(input int first, input int last);
    int n;
    n = 0;
    for (int i = first; i <= last; i++)
      if (i >= sd_q.size() || sd_q[i] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int ws_mismatches(input int base);
    int  m;
    logic e;
    m = 0;
    for (int k = 0; k < 64; k++) begin
      e = (k >= 31) && (k <= 62);
      if (base + k >= ws_q.size() || ws_q[base + k] !== e) m++;
    end
    return m;
  endfunction

  initial begin
    // Reset with the clock stopped
    #2 rst_in = 1'b1;
    #2;
    check("rst_sck", 32'(i2s_sck_out), 32'd0);
    check("rst_ws", 32'(i2s_ws_out), 32'd0);
    check("rst_sd", 32'(i2s_sd_out), 32'd0);
    check("rst_underrun", 32'(underrun_out), 32'd0);
    check("rst_ready", 32'(sample_ready_out), 32'd1);
    #1 rst_in = 1'b0;
    clk_en = 1'b1;
    ticks(4);
    clear_log();
    ticks(40);
    check("idle_no_sck", 32'(sd_q.size()), 32'd0);

    // Single frame
    left_in = 16'hA5C3; right_in = 16'h8001; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    check("single_ready_low", 32'(sample_ready_out), 32'd0);
    clear_log();
    enable_in = 1'b1;
    ticks(256);
    check("single_no_underrun", 32'(und_cnt), 32'd0);
    ticks(272);
    check("single_lead_bit", 32'(sd_q[0]), 32'd0);
    check("single_left", 32'(word_at(1)), 32'h0000A5C3);
    check("single_left_pad", 32'(word_at(17)), 32'd0);
    check("single_right", 32'(word_at(33)), 32'h00008001);
    check("single_right_pad", 32'(word_at(49)), 32'd0);
    check("single_ws_pattern", 32'(ws_mismatches(1)), 32'd0);
    enable_in = 1'b0;
    ticks(300);
    check("single_idle_sck", 32'(i2s_sck_out), 32'd0);
    check("single_idle_ws", 32'(i2s_ws_out), 32'd0);

    // Empty buffer
    clear_log();
    enable_in = 1'b1;
    ticks(768);
    check("empty_underruns", 32'(und_cnt), 32'd3);
    check("empty_spacing", 32'(und_last - und_first), 32'd512);
    check("empty_sd_zero", 32'(ones_in(0, sd_q.size() - 1)), 32'd0);
    enable_in = 1'b0;
    ticks(300);

    // Stop mid-frame, then restart
    left_in = 16'h1234; right_in = 16'hFEDC; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    clear_log();
    enable_in = 1'b1;
    ticks(42);
    enable_in = 1'b0;
    ticks(400);
    check("stop_rises", 32'(sd_q.size()), 32'd64);
    check("stop_left", 32'(word_at(1)), 32'h00001234);
    check("stop_right", 32'(word_at(33)), 32'h0000FEDC);
    check("stop_no_underrun", 32'(und_cnt), 32'd0);
    check("stop_sck", 32'(i2s_sck_out), 32'd0);
    check("stop_ws", 32'(i2s_ws_out), 32'd0);
    check("stop_sd", 32'(i2s_sd_out), 32'd0);
    left_in = 16'h0F0F; right_in = 16'hF0F0; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    clear_log();
    enable_in = 1'b1;
    ticks(300);
    check("restart_lead_bit", 32'(sd_q[0]), 32'd0);
    check("restart_left", 32'(word_at(1)), 32'h00000F0F);
    check("restart_right", 32'(word_at(33)), 32'h0000F0F0);
    enable_in = 1'b0;
    ticks(300);

    // Back-to-back stream
    acc = 0;
    left_in = 16'h1000; right_in = 16'h2000; sample_valid_in = 1'b1;
    stream_on = 1'b1;
    tick();
    check("stream_ready_falls", 32'(sample_ready_out), 32'd0);
    clear_log();
    ready_prev = sample_ready_out;
    enable_in = 1'b1;
    ticks(1024);
    check("stream_ready_rises", 32'(ready_rises), 32'd4);
    check("stream_no_underrun", 32'(und_cnt), 32'd0);
    ticks(6);
    stream_on = 1'b0;
    sample_valid_in = 1'b0;
    enable_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("stream_left%0d", n), 32'(word_at(1 + 64 * n)), 32'h1000 + 32'(n));
      check($sformatf("stream_right%0d", n), 32'(word_at(33 + 64 * n)), 32'h2000 + 32'(n));
    end
    ticks(400);

    // Asynchronous reset mid-frame with a full buffer
    clear_log();
    enable_in = 1'b1;
    tick();
    left_in = 16'h5555; right_in = 16'hAAAA; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    ticks(160);
    check("mid_pre_sck", 32'(i2s_sck_out), 32'd1);
    check("mid_pre_ws", 32'(i2s_ws_out), 32'd1);
    check("mid_pre_ready", 32'(sample_ready_out), 32'd0);
    #2 rst_in = 1'b1;
    #1;
    check("mid_rst_sck", 32'(i2s_sck_out), 32'd0);
    check("mid_rst_ws", 32'(i2s_ws_out), 32'd0);
    check("mid_rst_sd", 32'(i2s_sd_out), 32'd0);
    check("mid_rst_underrun", 32'(underrun_out), 32'd0);
    check("mid_rst_ready", 32'(sample_ready_out), 32'd1);
    enable_in = 1'b0;
    tick();
    rst_in = 1'b0;
    ticks(20);
    check("mid_after_ready", 32'(sample_ready_out), 32'd1);
    check("mid_after_sck", 32'(i2s_sck_out), 32'd0);

    // Transfer on the empty-buffer frame-load cycle
    clear_log();
    left_in = 16'hBEEF; right_in = 16'h7A5A; sample_valid_in = 1'b1;
    enable_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    check("sim_underrun_pulse", 32'(underrun_out), 32'd1);
    check("sim_ready_low", 32'(sample_ready_out), 32'd0);
    tick();
    check("sim_underrun_one_cycle", 32'(underrun_out), 32'd0);
    ticks(510);
    check("sim_underruns", 32'(und_cnt), 32'd1);
    ticks(16);
    check("sim_zero_frame", 32'(ones_in(1, 64)), 32'd0);
    check("sim_next_left", 32'(word_at(65)), 32'h0000BEEF);
    check("sim_next_right", 32'(word_at(97)), 32'h00007A5A);
    enable_in = 1'b0;
    ticks(300);
    check("final_sck", 32'(i2s_sck_out), 32'd0);
    check("final_sd", 32'(i2s_sd_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
